// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Write buffer between the core's MEM stage and the data memory. Stores are
//   queued in a small circular FIFO and drained to memory in program order on
//   cycles where no load needs the memory port. Loads own the port when they
//   are present and are forwarded from the youngest matching buffered store.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous active-high reset, clears all buffer state
//   st_valid         store request          st_addr / st_data  store payload
//   st_ready         buffer has room for a store this cycle
//   ld_valid         load request           ld_addr            load byte address
//   ld_data          load result (combinational)
//   ld_fwd           ld_data was taken from the buffer
//   empty            no pending stores (fence / drain-complete flag)
//   count            number of pending stores
//   mem_access_addr  memory address        mem_write_data     memory write data
//   mem_write_en     memory write strobe   mem_read           memory read strobe
//   mem_read_data    memory read data (combinational)
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [15:0]              st_addr,
    input  logic [15:0]              st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [15:0]              ld_addr,
    output logic [15:0]              ld_data,
    output logic                     ld_fwd,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              mem_access_addr,
    output logic [15:0]              mem_write_data,
    output logic                     mem_write_en,
    output logic                     mem_read,
    input  logic [15:0]              mem_read_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage; contents are meaningless outside [rd_ptr, rd_ptr+count).
    logic [15:0]   addr_q [DEPTH];
    logic [15:0]   data_q [DEPTH];

    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic          empty_s;
    logic          ready_s;
    logic          push_s;
    logic          pop_s;
    logic          fwd_hit_s;
    logic [15:0]   fwd_data_s;
    logic          hit_s;
    logic [PW-1:0] slot_s;

    // Occupancy flags and handshake qualifiers. A full buffer never accepts,
    // even when a drain frees a slot in the same cycle.
    always_comb begin
        empty_s = (count_q == {CW{1'b0}});
        ready_s = (count_q != CW'(DEPTH));
        push_s  = st_valid && ready_s;
        pop_s   = !ld_valid && !empty_s;
    end

    assign empty    = empty_s;
    assign st_ready = ready_s;
    assign count    = count_q;

    // Pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_q[wr_ptr_q] <= st_addr;
            data_q[wr_ptr_q] <= st_data;
        end
    end

    // Forwarding search: walk oldest to youngest so the last hit is the
    // youngest matching store. Only word index bits [8:1] take part.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = 16'h0000;
        hit_s      = 1'b0;
        slot_s     = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            slot_s     = rd_ptr_q + PW'(i);
            hit_s      = (CW'(i) < count_q) && (addr_q[slot_s][8:1] == ld_addr[8:1]);
            fwd_data_s = hit_s ? data_q[slot_s] : fwd_data_s;
            fwd_hit_s  = fwd_hit_s | hit_s;
        end
    end

    // Memory port arbitration: load first, then drain the head entry.
    always_comb begin
        mem_read        = 1'b0;
        mem_write_en    = 1'b0;
        mem_access_addr = 16'h0000;
        mem_write_data  = 16'h0000;
        ld_data         = 16'h0000;
        ld_fwd          = 1'b0;
        if (ld_valid) begin
            mem_read        = 1'b1;
            mem_access_addr = ld_addr;
            ld_data         = fwd_hit_s ? fwd_data_s : mem_read_data;
            ld_fwd          = fwd_hit_s;
        end else if (!empty_s) begin
            mem_write_en    = 1'b1;
            mem_access_addr = addr_q[rd_ptr_q];
            mem_write_data  = data_q[rd_ptr_q];
        end else begin
            mem_read        = 1'b0;
            mem_write_en    = 1'b0;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_fwd;
    logic        empty;
    logic [2:0]  count;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read;
    logic [15:0] mem_read_data;

    // Data memory attached to the port: 256 words indexed by addr[8:1].
    logic [15:0] mem [256] = '{default: 16'h0000};

    // Reference model: pending stores in program order plus expected memory.
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;
    ent_t        q[$];
    logic [15:0] ref_mem [256];

    int total = 0;
    int bad   = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .st_valid        (st_valid),
        .st_addr         (st_addr),
        .st_data         (st_data),
        .st_ready        (st_ready),
        .ld_valid        (ld_valid),
        .ld_addr         (ld_addr),
        .ld_data         (ld_data),
        .ld_fwd          (ld_fwd),
        .empty           (empty),
        .count           (count),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_access_addr[8:1]] <= mem_write_data;
    end

    assign mem_read_data = mem[mem_access_addr[8:1]];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Drive one cycle's inputs (called just after a falling edge) and settle.
    task automatic apply(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                         input logic lv, input logic [15:0] la);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_valid = lv;
        ld_addr  = la;
        #1;
    endtask

    // Clock edge: advance the reference model using the applied inputs.
    task automatic advance();
        @(posedge clk);
        if (!reset) begin
            logic acc;
            logic pop;
            acc = st_valid && (q.size() < DEPTH);
            pop = !ld_valid && (q.size() > 0);
            if (pop) begin
                ref_mem[q[0].a[8:1]] = q[0].d;
                void'(q.pop_front());
            end
            if (acc) q.push_back({st_addr, st_data});
        end
        @(negedge clk);
    endtask

    function automatic logic exp_fwd(input logic lv, input logic [15:0] la);
        logic h;
        h = 1'b0;
        if (lv) begin
            foreach (q[i]) if (q[i].a[8:1] == la[8:1]) h = 1'b1;
        end
        return h;
    endfunction

    function automatic logic [15:0] exp_ld_data(input logic lv, input logic [15:0] la);
        logic [15:0] r;
        if (!lv) return 16'h0000;
        r = ref_mem[la[8:1]];
        foreach (q[i]) if (q[i].a[8:1] == la[8:1]) r = q[i].d;
        return r;
    endfunction

    task automatic drain_all();
        apply(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        for (int n = 0; n < 20 && !empty; n++) advance();
        total++;
        if (!empty || q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got_empty=%0b model_left=%0d required=empty", empty, q.size());
        end
    endtask

    task automatic test_reset();
        total++;
        if (count !== 3'd0 || empty !== 1'b1 || st_ready !== 1'b1 || mem_write_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got count=%0d empty=%0b rdy=%0b we=%0b required 0 1 1 0",
                     count, empty, st_ready, mem_write_en);
        end
        ld_valid = 1'b1;
        #1;
        total++;
        if (mem_read !== 1'b1) begin
            bad++;
            $display("FAIL reset_mem_read got=%0b required=1", mem_read);
        end
        ld_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 16'h0010 + 16'(2 * i), 16'h00A0 + 16'(i), 1'b1, 16'h0100);
            advance();
        end
        apply(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        total++;
        if (count !== 3'd3 || mem_write_en !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre got count=%0d we=%0b required 3 1", count, mem_write_en);
        end
        #1;
        reset = 1'b1;
        #1;
        q.delete();
        total++;
        if (count !== 3'd0 || empty !== 1'b1 || st_ready !== 1'b1 || mem_write_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_async got count=%0d empty=%0b rdy=%0b we=%0b required 0 1 1 0",
                     count, empty, st_ready, mem_write_en);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
            total++;
            if (mem_write_en !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_write got=%0b required=0", mem_write_en);
            end
            advance();
        end
        for (int w = 8; w <= 10; w++) begin
            total++;
            if (mem[w] !== 16'h0000) begin
                bad++;
                $display("FAIL reset_mem word=%0h got=%h required=0000", w, mem[w]);
            end
        end
    endtask

    task automatic test_single_store();
        apply(1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000);
        advance();
        apply(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        total++;
        if (mem_write_en !== 1'b1 || mem_access_addr !== 16'h0010 || mem_write_data !== 16'hBEEF) begin
            bad++;
            $display("FAIL single_drain got we=%0b addr=%h data=%h required 1 0010 beef",
                     mem_write_en, mem_access_addr, mem_write_data);
        end
        advance();
        total++;
        if (mem_write_en !== 1'b0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL single_after got we=%0b empty=%0b required 0 1", mem_write_en, empty);
        end
        apply(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010);
        total++;
        if (ld_data !== 16'hBEEF || ld_fwd !== 1'b0) begin
            bad++;
            $display("FAIL single_load got data=%h fwd=%0b required beef 0", ld_data, ld_fwd);
        end
        advance();
    endtask

    task automatic test_fill_order();
        for (int i = 1; i <= 4; i++) begin
            apply(1'b1, 16'(2 * i), 16'(i), 1'b1, 16'h0100);
            advance();
        end
        apply(1'b1, 16'h000A, 16'h0005, 1'b1, 16'h0100);
        total++;
        if (st_ready !== 1'b0 || count !== 3'd4) begin
            bad++;
            $display("FAIL fill_full got rdy=%0b count=%0d required 0 4", st_ready, count);
        end
        advance();
        apply(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (mem_write_en !== 1'b1 || mem_access_addr !== 16'(2 * i) || mem_write_data !== 16'(i)) begin
                bad++;
                $display("FAIL fill_order i=%0d got we=%0b addr=%h data=%h required 1 %h %h",
                         i, mem_write_en, mem_access_addr, mem_write_data, 16'(2 * i), 16'(i));
            end
            advance();
        end
        total++;
        if (empty !== 1'b1 || mem_write_en !== 1'b0) begin
            bad++;
            $display("FAIL fill_empty got empty=%0b we=%0b required 1 0", empty, mem_write_en);
        end
    endtask

    task automatic test_forward_youngest();
        apply(1'b1, 16'h0020, 16'h1111, 1'b1, 16'h0100);
        advance();
        apply(1'b1, 16'h0020, 16'h2222, 1'b1, 16'h0100);
        advance();
        apply(1'b1, 16'h0020, 16'h3333, 1'b1, 16'h0021);
        total++;
        if (ld_data !== 16'h2222 || ld_fwd !== 1'b1) begin
            bad++;
            $display("FAIL fwd_same_cycle got data=%h fwd=%0b required 2222 1", ld_data, ld_fwd);
        end
        advance();
        apply(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0021);
        total++;
        if (ld_data !== 16'h3333 || ld_fwd !== 1'b1) begin
            bad++;
            $display("FAIL fwd_youngest got data=%h fwd=%0b required 3333 1", ld_data, ld_fwd);
        end
        advance();
        drain_all();
    endtask

    task automatic test_miss();
        apply(1'b1, 16'h0060, 16'h5A5A, 1'b0, 16'h0000);
        advance();
        drain_all();
        apply(1'b1, 16'h0040, 16'h0001, 1'b1, 16'h0100);
        advance();
        apply(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0060);
        total++;
        if (ld_data !== 16'h5A5A || ld_fwd !== 1'b0 || mem_read !== 1'b1 || mem_access_addr !== 16'h0060) begin
            bad++;
            $display("FAIL miss got data=%h fwd=%0b rd=%0b addr=%h required 5a5a 0 1 0060",
                     ld_data, ld_fwd, mem_read, mem_access_addr);
        end
        advance();
        drain_all();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 16'h0080 + 16'(2 * i), 16'h7000 + 16'(i), 1'b0, 16'h0000);
            if (i > 0) begin
                total++;
                if (count !== 3'd1 || mem_write_en !== 1'b1 ||
                    mem_access_addr !== 16'h0080 + 16'(2 * (i - 1)) ||
                    mem_write_data !== 16'h7000 + 16'(i - 1)) begin
                    bad++;
                    $display("FAIL wrap_stream i=%0d got count=%0d we=%0b addr=%h data=%h required 1 1 %h %h",
                             i, count, mem_write_en, mem_access_addr, mem_write_data,
                             16'h0080 + 16'(2 * (i - 1)), 16'h7000 + 16'(i - 1));
                end
            end
            advance();
        end
        drain_all();
        for (int i = 0; i < 10; i++) begin
            total++;
            if (mem[8'h40 + 8'(i)] !== 16'h7000 + 16'(i)) begin
                bad++;
                $display("FAIL wrap_mem i=%0d got=%h required=%h", i, mem[8'h40 + 8'(i)], 16'h7000 + 16'(i));
            end
        end
    endtask

    task automatic test_random();
        logic        sv;
        logic        lv;
        logic [15:0] sa;
        logic [15:0] la;
        logic [15:0] sd;
        logic        e_we;
        logic [15:0] e_addr;
        logic [15:0] e_wd;
        for (int c = 0; c < 500; c++) begin
            sv = ($urandom_range(0, 99) < 60);
            lv = ($urandom_range(0, 99) < 40);
            sa = 16'($urandom);
            sa[8:1] = 8'h40 + 8'($urandom_range(0, 7));
            la = 16'($urandom);
            la[8:1] = 8'h40 + 8'($urandom_range(0, 7));
            sd = 16'($urandom);
            apply(sv, sa, sd, lv, la);
            e_we   = !lv && (q.size() > 0);
            e_addr = lv ? la : (e_we ? q[0].a : 16'h0000);
            e_wd   = e_we ? q[0].d : 16'h0000;
            total++;
            if (ld_data !== exp_ld_data(lv, la) || ld_fwd !== exp_fwd(lv, la)) begin
                bad++;
                $display("FAIL rnd_load c=%0d got data=%h fwd=%0b required %h %0b",
                         c, ld_data, ld_fwd, exp_ld_data(lv, la), exp_fwd(lv, la));
            end
            total++;
            if (count !== 3'(q.size()) || empty !== (q.size() == 0) || st_ready !== (q.size() < DEPTH)) begin
                bad++;
                $display("FAIL rnd_flags c=%0d got count=%0d empty=%0b rdy=%0b required count=%0d",
                         c, count, empty, st_ready, q.size());
            end
            total++;
            if (mem_read !== lv || mem_write_en !== e_we || mem_access_addr !== e_addr ||
                (!lv && mem_write_data !== e_wd)) begin
                bad++;
                $display("FAIL rnd_port c=%0d got rd=%0b we=%0b addr=%h wd=%h required %0b %0b %h %h",
                         c, mem_read, mem_write_en, mem_access_addr, mem_write_data, lv, e_we, e_addr, e_wd);
            end
            advance();
        end
        drain_all();
        for (int w = 0; w < 256; w++) begin
            total++;
            if (mem[w] !== ref_mem[w]) begin
                bad++;
                $display("FAIL rnd_mem word=%0h got=%h required=%h", w, mem[w], ref_mem[w]);
            end
        end
    endtask

    initial begin
        for (int w = 0; w < 256; w++) ref_mem[w] = 16'h0000;
        reset    = 1'b1;
        st_valid = 1'b0;
        st_addr  = 16'h0000;
        st_data  = 16'h0000;
        ld_valid = 1'b0;
        ld_addr  = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_single_store();
        test_fill_order();
        test_forward_youngest();
        test_miss();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write buffer between the 16-bit MIPS core's MEM stage and the data `memory` block. It queues stores so the pipeline does not wait on the memory port, and drains them to `memory` in program order when loads are not using the port. Loads take priority on the port and are forwarded from the newest matching buffered store. It owns `memory`'s `mem_access_addr`, `mem_write_data`, `mem_write_en` and `mem_read`, and observes `mem_read_data`.

## Interface
- DEPTH, 4, number of store entries; power of two, at least 2.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all buffer state immediately.
- st_valid  in  1  store request from the MEM stage.
- st_addr  in  16  store byte address.
- st_data  in  16  store data.
- st_ready  out  1  buffer can accept a store this cycle.
- ld_valid  in  1  load request from the MEM stage.
- ld_addr  in  16  load byte address.
- ld_data  out  16  load result, combinational, same cycle.
- ld_fwd  out  1  ld_data came from the buffer, not memory.
- empty  out  1  no pending stores; the core uses it as the fence/drain-complete flag.
- count  out  log2(DEPTH)+1  number of pending entries.
- mem_access_addr  out  16  to memory.
- mem_write_data  out  16  to memory.
- mem_write_en  out  1  to memory.
- mem_read  out  1  to memory.
- mem_read_data  in  16  from memory; combinational read.

## Operation
- **Storage.** Circular FIFO of DEPTH entries, each holding {addr[15:0], data[15:0]}. It uses head pointer `rd_ptr`, tail pointer `wr_ptr` (each log2(DEPTH) bits, wrapping modulo DEPTH) and `count`.
- **Flags.**
  - st_ready = (count != DEPTH).
  - empty = (count == 0).
  - There is no pass-through when full: a store arriving while full is not accepted even if a drain happens in the same cycle.
- **Push.** When st_valid && st_ready, the buffer writes {st_addr, st_data} at wr_ptr, and wr_ptr advances at the clock edge.
- **Port arbitration (combinational).**
  - Load has priority. If ld_valid, the buffer drives mem_read=1, mem_access_addr=ld_addr, mem_write_en=0.
  - Otherwise, if !empty, it drains: mem_read=0, mem_write_en=1, mem_access_addr=head addr, mem_write_data=head data.
  - Otherwise all memory controls are 0 and the address/data outputs are 0.
- **Pop.** A drain cycle commits the write in memory at the clock edge; rd_ptr advances at that same edge.
- **Count update.** count +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- **Word match.** Two addresses match when addr[8:1] are equal, which is the same word index memory uses. Bit 0 and bits 15:9 are ignored.
- **Forwarding.**
  - For ld_valid, every valid entry is compared with ld_addr.
  - If any entry matches, ld_data = data of the youngest matching entry (closest to the tail) and ld_fwd=1.
  - Otherwise ld_data = mem_read_data and ld_fwd=0.
  - When ld_valid=0: ld_data=0, ld_fwd=0.
- **Same-cycle load and store.** A store pushed in the same cycle as a load is not visible to that load. The pipeline issues the older operation first, so this is correct ordering.
- **Loads block draining.** A continuous stream of loads stalls draining indefinitely. This is allowed; stores make progress on the first cycle without ld_valid.

## Timing
- **Reset values** (reset asserted, effective immediately without clk):
  - rd_ptr=0, wr_ptr=0, count=0
  - empty=1, st_ready=1
  - mem_write_en=0, mem_read=ld_valid
  - entries' contents don't-care
- **Reset mid-operation.** All pending stores are discarded and none is written afterwards. A drain in progress in that cycle is suppressed because mem_write_en drops asynchronously.
- **Latencies.**
  - Store accepted at edge N becomes visible to forwarding from cycle N+1.
  - Its earliest drain cycle is N+1, and memory is updated at edge N+2 if no load occupies the port.
  - Load latency is 0 cycles (combinational).
- **Throughput.** Drain rate is 1 store/cycle. Push rate is 1 store/cycle while not full.
- **Wrap-around.** Pointers wrap from DEPTH−1 to 0 with no bubble.

## Test plan
- **Reset.** Assert reset mid-cycle with 3 entries pending → count=0, empty=1, st_ready=1, mem_write_en=0 immediately. After release, no memory write occurs, and memory words 0x08/0x09/0x0A still read 0.
- **Single store.** Store 0x0010←0xBEEF, ld_valid=0 → next cycle mem_write_en=1, mem_access_addr=0x0010, mem_write_data=0xBEEF for exactly one cycle. Then empty=1, and a load of 0x0010 returns 0xBEEF with ld_fwd=0.
- **Fill and order.** Hold ld_valid=1 (addr 0x0100) and push stores to 0x0002/0x0004/0x0006/0x0008 with data 1..4 → st_ready=0 and count=4 after the 4th; a 5th st_valid is not accepted. Drop ld_valid → four consecutive write cycles in order 0x0002..0x0008, then empty=1.
- **Forwarding, youngest wins.** With draining blocked, store 0x0020←0x1111 then 0x0020←0x2222, then load 0x0021 → ld_data=0x2222, ld_fwd=1.
- **Miss.** Memory word 0x30 holds 0x5A5A, buffer holds 0x0040←0x0001, load 0x0060 → ld_data=0x5A5A, ld_fwd=0, mem_read=1.
- **Simultaneous push/pop and wrap.** Run 10 cycles of continuous stores with ld_valid=0 → count stays at 1 after the first edge, pointers wrap past DEPTH−1, and all 10 writes reach memory in order.
